// File: rtl/resized_crop.sv
// Random square crop followed by nearest-neighbour resize back to IMG_W x IMG_H,
// streaming source pixels from a synchronous-read BRAM, one word per pixel.
module resized_crop #(
    parameter int          IMG_W     = 28,
    parameter int          IMG_H     = 28,
    parameter int          MIN_CROP  = 14,
    parameter logic [31:0] BASE_ADDR = 32'd0,
    parameter bit          RAND_EN   = 1'b1,
    parameter logic [15:0] SEED      = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        interrupt,
    output logic        image_done,
    output logic [7:0]  pixel_o,
    output logic        pixel_valid,
    output logic [31:0] bram_address,
    input  logic [31:0] bram_data
);

    localparam logic [15:0] W16   = 16'(IMG_W);
    localparam logic [15:0] H16   = 16'(IMG_H);
    localparam logic [15:0] WM1   = 16'(IMG_W - 1);
    localparam logic [15:0] HM1   = 16'(IMG_H - 1);
    localparam logic [15:0] MIN16 = 16'(MIN_CROP);
    localparam logic [31:0] W32   = 32'(IMG_W);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DRAIN} state_t;

    state_t      state_q, state_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic [15:0] s_q, s_d;
    logic [15:0] ox_q, ox_d, oy_q, oy_d;
    logic [15:0] rx_q, rx_d, ry_q, ry_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] row_q, row_d;
    logic        issue_q, issue_d;
    logic        done_q, done_d;
    logic        valid_q;
    logic [7:0]  pixel_q;

    logic [15:0] s_calc, x0_calc, y0_calc;
    logic [15:0] rx_sum, ry_sum;
    logic        unused_bits;

    assign unused_bits = ^bram_data[31:8];

    // Crop window derived from the LFSR value present during LOAD.
    always_comb begin
        s_calc = MIN16 + {12'd0, lfsr_q[3:0]};
        if (s_calc > W16) begin
            s_calc = W16;
        end
        x0_calc = {11'd0, lfsr_q[8:4]};
        if (x0_calc > W16 - s_calc) begin
            x0_calc = W16 - s_calc;
        end
        y0_calc = {11'd0, lfsr_q[13:9]};
        if (y0_calc > H16 - s_calc) begin
            y0_calc = H16 - s_calc;
        end
        if (!RAND_EN) begin
            s_calc  = W16;
            x0_calc = 16'd0;
            y0_calc = 16'd0;
        end
    end

    // rx/ry hold (o*S mod dim); an overflow means the floor term stepped by one.
    always_comb begin
        state_d  = state_q;
        lfsr_d   = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        s_d      = s_q;
        ox_d     = ox_q;
        oy_d     = oy_q;
        rx_d     = rx_q;
        ry_d     = ry_q;
        addr_d   = addr_q;
        row_d    = row_q;
        issue_d  = 1'b0;
        done_d   = 1'b0;
        rx_sum   = rx_q + s_q;
        ry_sum   = ry_q + s_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                s_d     = s_calc;
                ox_d    = 16'd0;
                oy_d    = 16'd0;
                rx_d    = 16'd0;
                ry_d    = 16'd0;
                row_d   = BASE_ADDR + 32'(y0_calc) * W32 + 32'(x0_calc);
                addr_d  = row_d;
                state_d = RUN;
            end
            RUN: begin
                if (!interrupt) begin
                    issue_d = 1'b1;
                    if (ox_q == WM1) begin
                        ox_d = 16'd0;
                        rx_d = 16'd0;
                        if (oy_q == HM1) begin
                            done_d  = 1'b1;
                            state_d = DRAIN;
                        end else begin
                            oy_d = oy_q + 16'd1;
                            if (ry_sum >= H16) begin
                                ry_d   = ry_sum - H16;
                                row_d  = row_q + W32;
                                addr_d = row_q + W32;
                            end else begin
                                ry_d   = ry_sum;
                                addr_d = row_q;
                            end
                        end
                    end else begin
                        ox_d = ox_q + 16'd1;
                        if (rx_sum >= W16) begin
                            rx_d   = rx_sum - W16;
                            addr_d = addr_q + 32'd1;
                        end else begin
                            rx_d = rx_sum;
                        end
                    end
                end
            end
            DRAIN: begin
                // The last issued read lands one cycle after issue_q clears.
                if (!issue_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            lfsr_q  <= SEED;
            s_q     <= W16;
            ox_q    <= 16'd0;
            oy_q    <= 16'd0;
            rx_q    <= 16'd0;
            ry_q    <= 16'd0;
            addr_q  <= BASE_ADDR;
            row_q   <= BASE_ADDR;
            issue_q <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            pixel_q <= 8'd0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            s_q     <= s_d;
            ox_q    <= ox_d;
            oy_q    <= oy_d;
            rx_q    <= rx_d;
            ry_q    <= ry_d;
            addr_q  <= addr_d;
            row_q   <= row_d;
            issue_q <= issue_d;
            done_q  <= done_d;
            valid_q <= issue_q;
            if (issue_q) begin
                pixel_q <= bram_data[7:0];
            end
        end
    end

    assign bram_address = addr_q;
    assign pixel_o      = pixel_q;
    assign pixel_valid  = valid_q;
    assign image_done   = done_q;

endmodule

// File: tb/tb_resized_crop.sv
// Scoreboard bench for resized_crop: a full-image instance and a random-crop
// instance share one BRAM image; expected pixels come from a division-based model.
module tb_resized_crop;

    localparam int          W    = 28;
    localparam int          H    = 28;
    localparam int          MINC = 14;
    localparam int          NPIX = W * H;
    localparam logic [31:0] BASE = 32'd0;
    localparam logic [15:0] SEED = 16'hACE1;

    typedef struct packed {
        logic [31:0] a;
        logic [7:0]  p;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]       rst;
    logic [1:0]       start;
    logic [1:0]       intr;
    logic [1:0]       done;
    logic [1:0]       valid;
    logic [1:0][7:0]  pix;
    logic [1:0][31:0] addr;
    logic [1:0][31:0] rdata;

    logic [31:0] mem [0:1023];
    logic [15:0] mlfsr [2];
    logic [31:0] h1 [2];
    logic [31:0] h2 [2];
    int          vcnt [2] = '{0, 0};
    int          dcnt [2] = '{0, 0};
    exp_t        exp_q [$];
    int          checks = 0;
    int          errors = 0;

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        resized_crop #(
            .IMG_W(W), .IMG_H(H), .MIN_CROP(MINC), .BASE_ADDR(BASE),
            .RAND_EN(gi == 1), .SEED(SEED)
        ) u_dut (
            .clk(clk), .reset(rst[gi]), .start(start[gi]), .interrupt(intr[gi]),
            .image_done(done[gi]), .pixel_o(pix[gi]), .pixel_valid(valid[gi]),
            .bram_address(addr[gi]), .bram_data(rdata[gi])
        );
    end

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    // BRAM with one-cycle read latency, plus the reference LFSR for each instance.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            rdata[i] <= mem[addr[i][9:0]];
            if (rst[i]) mlfsr[i] <= SEED;
            else        mlfsr[i] <= lfsr_next(mlfsr[i]);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Monitor: a valid pixel belongs to the address presented two cycles earlier.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst[i]) begin
                if (valid[i]) begin
                    vcnt[i] <= vcnt[i] + 1;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_pixel dut%0d: got addr %0h pixel %0h, required no pixel",
                                 i, h2[i], pix[i]);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        chk("pixel_addr", h2[i], e.a);
                        chk("pixel_data", {24'd0, pix[i]}, {24'd0, e.p});
                    end
                end
                if (done[i]) dcnt[i] <= dcnt[i] + 1;
            end
            h2[i] <= h1[i];
            h1[i] <= addr[i];
        end
    end

    // Expected stream for one image, from the LFSR value seen during LOAD.
    task automatic push_image(input int i);
        int          s, x0, y0, a;
        logic [15:0] l;
        exp_t        e;
        l  = mlfsr[i];
        s  = MINC + int'(l[3:0]);
        if (s > W) s = W;
        x0 = int'(l[8:4]);
        if (x0 > W - s) x0 = W - s;
        y0 = int'(l[13:9]);
        if (y0 > H - s) y0 = H - s;
        if (i == 0) begin
            s  = W;
            x0 = 0;
            y0 = 0;
        end
        $display("image dut%0d: lfsr=%04h S=%0d x0=%0d y0=%0d", i, l, s, x0, y0);
        for (int oy = 0; oy < H; oy++) begin
            for (int ox = 0; ox < W; ox++) begin
                a   = int'(BASE) + (y0 + oy * s / H) * W + x0 + ox * s / W;
                e.a = 32'(a);
                e.p = mem[a][7:0];
                exp_q.push_back(e);
            end
        end
    endtask

    // Called mid-cycle; start is sampled at the next edge.
    task automatic do_start(input int i, input int hold);
        start[i] = 1'b1;
        @(posedge clk);
        #1;
        push_image(i);
        if (hold > 1) begin
            @(posedge clk);
            #1;
        end
        start[i] = 1'b0;
    endtask

    task automatic first_valid_latency(input int i);
        int k;
        k = 0;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (valid[i] && k == 0) k = n;
        end
        chk("first_valid_latency", 32'(k), 32'd4);
    endtask

    task automatic wait_done(input int i, input bit rnd_int);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 20000) begin
            @(posedge clk);
            #1;
            if (rnd_int) intr[i] = ($urandom_range(0, 3) == 0);
            n++;
        end
        intr[i] = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL image_timeout dut%0d: got %0d pixels outstanding, required 0", i, exp_q.size());
            exp_q.delete();
        end
        repeat (40) @(posedge clk);
        #1;
    endtask

    task automatic fill_random();
        for (int n = 0; n < 1024; n++) mem[n] = $urandom;
    endtask

    initial begin
        int v0, d0, nv, late;
        logic [31:0] a0;
        rst   = 2'b11;
        start = 2'b00;
        intr  = 2'b00;
        for (int n = 0; n < 1024; n++) mem[n] = 32'(n);
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("reset_pixel_o", {24'd0, pix[i]}, 32'd0);
            chk("reset_pixel_valid", 32'(valid[i]), 32'd0);
            chk("reset_image_done", 32'(done[i]), 32'd0);
            chk("reset_bram_address", addr[i], BASE);
        end
        rst = 2'b00;

        // Full-image crop, start on the very first cycle after reset.
        v0 = vcnt[0];
        d0 = dcnt[0];
        do_start(0, 1);
        first_valid_latency(0);
        wait_done(0, 1'b0);
        chk("full_pixel_count", 32'(vcnt[0] - v0), 32'(NPIX));
        chk("full_done_pulses", 32'(dcnt[0] - d0), 32'd1);

        // Two consecutive random crops; the second is interrupted.
        fill_random();
        v0 = vcnt[1];
        d0 = dcnt[1];
        do_start(1, 1);
        wait_done(1, 1'b0);
        chk("rand1_pixel_count", 32'(vcnt[1] - v0), 32'(NPIX));
        chk("rand1_done_pulses", 32'(dcnt[1] - d0), 32'd1);

        fill_random();
        v0 = vcnt[1];
        d0 = dcnt[1];
        do_start(1, 1);
        repeat (150) @(posedge clk);
        #1;
        intr[1] = 1'b1;
        nv   = 0;
        late = 0;
        a0   = 32'd0;
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            if (j == 0) a0 = addr[1];
            else        chk("addr_frozen", addr[1], a0);
            if (valid[1]) begin
                nv++;
                if (j >= 2) late++;
            end
        end
        checks++;
        if (nv > 2) begin
            errors++;
            $display("FAIL valids_after_interrupt: got %0d, required at most 2", nv);
        end
        chk("late_valids_during_interrupt", 32'(late), 32'd0);
        @(posedge clk);
        #1;
        intr[1] = 1'b0;
        wait_done(1, 1'b1);
        chk("rand2_pixel_count", 32'(vcnt[1] - v0), 32'(NPIX));
        chk("rand2_done_pulses", 32'(dcnt[1] - d0), 32'd1);

        // Start held two cycles, plus a start pulse mid-image.
        fill_random();
        v0 = vcnt[1];
        d0 = dcnt[1];
        do_start(1, 2);
        repeat (300) @(posedge clk);
        #1;
        start[1] = 1'b1;
        @(posedge clk);
        #1;
        start[1] = 1'b0;
        wait_done(1, 1'b0);
        chk("start_ignore_pixel_count", 32'(vcnt[1] - v0), 32'(NPIX));
        chk("start_ignore_done_pulses", 32'(dcnt[1] - d0), 32'd1);

        // Asynchronous reset mid-RUN, then a restart from a re-seeded LFSR.
        fill_random();
        do_start(1, 1);
        repeat (200) @(posedge clk);
        d0 = dcnt[1];
        @(posedge clk);
        #2;
        rst[1] = 1'b1;
        #1;
        chk("midreset_pixel_o", {24'd0, pix[1]}, 32'd0);
        chk("midreset_pixel_valid", 32'(valid[1]), 32'd0);
        chk("midreset_image_done", 32'(done[1]), 32'd0);
        chk("midreset_bram_address", addr[1], BASE);
        exp_q.delete();
        @(posedge clk);
        #1;
        chk("midreset_no_done", 32'(dcnt[1] - d0), 32'd0);
        rst[1] = 1'b0;
        v0 = vcnt[1];
        d0 = dcnt[1];
        do_start(1, 1);
        first_valid_latency(1);
        wait_done(1, 1'b0);
        chk("restart_pixel_count", 32'(vcnt[1] - v0), 32'(NPIX));
        chk("restart_done_pulses", 32'(dcnt[1] - d0), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
